aes_channel_arbiter: RTL
========================

// Module: aes_channel_arbiter
// PURPOSE
// - Shares one AES block engine among N_CH requester channels, one 128-bit block at a time.
// - Round-robin grant per block: latch block, pulse engine start, wait for done, return result to granting channel.
// - Sits between per-channel streamer FIFOs and the engine; replaces the single-channel FSM when multi-context encryption is enabled.
// PARAMETERS
// N_CH     4     number of requester channels (2..8)
// DW       128   block width in bits
// CW       16    per-channel completed-block counter width
// TIMEOUT  64    max cycles in WAIT before abort (>=2)
// PORTS
// clk            in   1          clock
// reset_n        in   1          async active-low reset
// clear          in   1          sync clear, same effect as reset
// ch_in_valid    in   N_CH       channel i has a block pending
// ch_in_data     in   N_CH*DW    channel i block, slice [i*DW +: DW]
// ch_in_ready    out  N_CH       one-hot accept strobe
// ch_out_valid   out  N_CH       result valid for channel i (at most one bit set)
// ch_out_data    out  DW         result data, shared by all channels
// ch_out_ready   in   N_CH       channel i accepts result
// core_start     out  1          one-cycle engine start pulse
// core_data      out  DW         block to engine, stable START..WAIT
// core_ch        out  $clog2(N_CH) granted channel id (engine selects key context)
// core_done      in   1          engine result valid, one cycle
// core_result    in   DW         engine result, sampled when core_done=1
// blk_cnt        out  N_CH*CW    per-channel completed blocks, saturating
// timeout_err    out  1          sticky; set on WAIT timeout, cleared by clear/reset
// BEHAVIOUR
// - Reset/clear: state IDLE, rr_ptr=0, all outputs 0, blk_cnt=0, timeout_err=0.
// - States: IDLE -> START -> WAIT -> RESP -> IDLE; WAIT -> IDLE on timeout.
// - IDLE: if any ch_in_valid, grant g = first valid channel at or after rr_ptr (wrap mod N_CH);
//   ch_in_ready[g]=1 same cycle (combinational), latch ch_in_data slice g and g; -> START.
// - START: core_start=1 for exactly one cycle; core_data/core_ch driven from latch; -> WAIT; timer=0.
// - WAIT: core_done=1 -> latch core_result, -> RESP. Else timer++; timer==TIMEOUT-1 -> timeout_err=1,
//   rr_ptr=g+1 (mod N_CH), -> IDLE; no result returned, blk_cnt unchanged.
// - core_done outside WAIT ignored (no state change, no latch).
// - RESP: ch_out_valid[g]=1, ch_out_data=latched result, held stable until ch_out_ready[g];
//   on handshake: blk_cnt[g]++ (saturate at 2^CW-1), rr_ptr=g+1 (mod N_CH), -> IDLE.
// - ch_out_ready of non-granted channels ignored.
// - Latency: accept at T, core_start at T+1, result visible cycle after core_done, next accept >= cycle after out handshake.
// - ch_in_ready never asserted outside IDLE; ch_in_ready, ch_out_valid and core_start never overlap.
// - core_data, core_ch, ch_out_data are 0 in IDLE.
// - Fairness: continuously valid channel granted at least once every N_CH blocks.
// - Async reset mid-operation: abort immediately, no result/count update; engine recovery is its own responsibility.
// - clear has priority over all state transitions in the same cycle.
// STRUCTURE
// - aes_package: arb_state_t {ARB_IDLE, ARB_START, ARB_WAIT, ARB_RESP}; AES_BLOCK_W=128.
// - Sub-module aes_rr_arbiter: combinational; inputs req[N_CH], ptr; outputs gnt one-hot, gnt_idx, any.
// - Top: state reg, rr_ptr, grant latch, data/result regs, timeout counter, blk_cnt array, error flag.
// TESTING
// - Single channel: ch1 valid, data=0x00112233..FF; core_done 10 cycles after start with 0xAA..AA ->
//   core_ch=1, one start pulse, ch_out_valid=4'b0010 with 0xAA..AA, blk_cnt[1]=1.
// - All 4 channels valid continuously, 8 blocks -> grant order 0,1,2,3,0,1,2,3; each blk_cnt=2.
// - rr_ptr=3 after ch2 served, valid only ch0,ch1 -> ch0 granted (wrap), then ch1.
// - Backpressure: ch_out_ready low 20 cycles in RESP -> data stable, no new ch_in_ready, counter updates on accept only.
// - Timeout: core_done never arrives -> IDLE after TIMEOUT cycles in WAIT, timeout_err=1, blk_cnt unchanged; spurious core_done in IDLE ignored.
// - clear asserted in WAIT, then core_done -> IDLE, all outputs 0, counters 0, done ignored; blk_cnt[0] saturates at 0xFFFF with CW=16.

Source files
------------

// File: rtl/aes_channel_arbiter_pkg.sv
// Shared types and helpers for the multi-channel AES engine arbiter.
package aes_channel_arbiter_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/aes_channel_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module aes_rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [N_CH-1:0]         gnt,
  output logic [$clog2(N_CH)-1:0] gnt_idx,
  output logic                    any
);

  localparam int IW = $clog2(N_CH);

  always_comb begin
    int unsigned c;
    c       = 32'd0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      c = (32'(ptr) + 32'(k)) % 32'(N_CH);
      if (!any && req[IW'(c)]) begin
        any          = 1'b1;
        gnt[IW'(c)]  = 1'b1;
        gnt_idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/aes_channel_arbiter.sv
// Time-shares one AES block engine among N_CH channels, one block per grant,
// round-robin, with a WAIT watchdog and per-channel completed-block counters.
module aes_channel_arbiter
  import aes_channel_arbiter_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DW      = AES_BLOCK_W,
  parameter int CW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [N_CH-1:0]         ch_in_valid,
  input  logic [N_CH*DW-1:0]      ch_in_data,
  output logic [N_CH-1:0]         ch_in_ready,
  output logic [N_CH-1:0]         ch_out_valid,
  output logic [DW-1:0]           ch_out_data,
  input  logic [N_CH-1:0]         ch_out_ready,
  output logic                    core_start,
  output logic [DW-1:0]           core_data,
  output logic [$clog2(N_CH)-1:0] core_ch,
  input  logic                    core_done,
  input  logic [DW-1:0]           core_result,
  output logic [N_CH*CW-1:0]      blk_cnt,
  output logic                    timeout_err
);

  localparam int IW = $clog2(N_CH);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_t                  state_q, state_d;
  logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]               gnt_idx_q, gnt_idx_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [N_CH-1:0][CW-1:0]     blk_cnt_q, blk_cnt_d;
  logic                        timeout_err_q, timeout_err_d;
  logic [DW-1:0]               blk_q, blk_d;
  logic [DW-1:0]               res_q, res_d;

  logic [N_CH-1:0]             arb_gnt;
  logic [IW-1:0]               arb_idx;
  logic                        arb_any;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
    return IW'(wrap_inc(32'(idx), N_CH));
  endfunction

  aes_rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req     (ch_in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_idx_d     = gnt_idx_q;
    timer_d       = timer_q;
    blk_cnt_d     = blk_cnt_q;
    timeout_err_d = timeout_err_q;
    blk_d         = blk_q;
    res_d         = res_q;
    ch_in_ready   = '0;
    ch_out_valid  = '0;
    ch_out_data   = '0;
    core_start    = 1'b0;
    core_data     = '0;
    core_ch       = '0;

    unique case (state_q)
      ARB_IDLE: begin
        // Accept is suppressed while clear/reset is active so no block is lost.
        if (arb_any && !clear && reset_n) begin
          ch_in_ready = arb_gnt;
          gnt_idx_d   = arb_idx;
          blk_d       = ch_in_data[arb_idx*DW +: DW];
          state_d     = ARB_START;
        end
      end
      ARB_START: begin
        core_start = 1'b1;
        core_data  = blk_q;
        core_ch    = gnt_idx_q;
        timer_d    = '0;
        state_d    = ARB_WAIT;
      end
      ARB_WAIT: begin
        core_data = blk_q;
        core_ch   = gnt_idx_q;
        if (core_done) begin
          res_d   = core_result;
          state_d = ARB_RESP;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr(gnt_idx_q);
          state_d       = ARB_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ARB_RESP: begin
        ch_out_valid[gnt_idx_q] = 1'b1;
        ch_out_data             = res_q;
        if (ch_out_ready[gnt_idx_q]) begin
          blk_cnt_d[gnt_idx_q] = sat_inc(blk_cnt_q[gnt_idx_q]);
          rr_ptr_d             = next_ptr(gnt_idx_q);
          state_d              = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (clear) begin
      state_d       = ARB_IDLE;
      rr_ptr_d      = '0;
      gnt_idx_d     = '0;
      timer_d       = '0;
      blk_cnt_d     = '0;
      timeout_err_d = 1'b0;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      gnt_idx_q     <= '0;
      timer_q       <= '0;
      blk_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_idx_q     <= gnt_idx_d;
      timer_q       <= timer_d;
      blk_cnt_q     <= blk_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Block and result holding registers; outputs are masked by state instead
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
    res_q <= res_d;
  end

  assign blk_cnt     = blk_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule
